cc_seq_ctrl: RTL

- Sequencing controller for the team's 4-bit mod-11 state counter (sequence 0→1→2→…→10→0).
- Owns the state register `ea` and decides when it advances: free-running, paused, single-stepped, or stopped after a programmed number of laps.
- The advance function is implemented inline.
- Sits between the front-panel/control logic (start/stop/step) and the display/decoder consuming `ea`.

---
 rtl/cc_seq_ctrl_if.sv | 54 +++++
 rtl/cc_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cc_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// cc_seq_ctrl_if
//
// Purpose:
//    Bundles the command inputs and status outputs of the mod-11 sequencing
//    controller. The front panel/control logic sits on the master side. The
//    controller itself sits on the slave side.
//
// Signals:
//    start    master->slave  begin a new run, or resume from pause
//    stop     master->slave  pause a run, or abort to idle
//    step     master->slave  single advance while paused (level sensitive)
//    ea       slave->master  current counter state, 0..10
//    wrap     slave->master  one-cycle pulse on the 10->0 advance
//    lap_cnt  slave->master  completed laps since last start, saturating
//    busy     slave->master  high while running
//    done     slave->master  high once the programmed lap count is reached
// ---------------------------------------------------------------------------
interface cc_seq_ctrl_if;

   logic       start;
   logic       stop;
   logic       step;
   logic [3:0] ea;
   logic       wrap;
   logic [7:0] lap_cnt;
   logic       busy;
   logic       done;

   // Control side: drives the commands and observes the counter state.
   modport master (
      output start,
      output stop,
      output step,
      input  ea,
      input  wrap,
      input  lap_cnt,
      input  busy,
      input  done
   );

   // Controller side: consumes the commands and owns the counter state.
   modport slave (
      input  start,
      input  stop,
      input  step,
      output ea,
      output wrap,
      output lap_cnt,
      output busy,
      output done
   );

endinterface

// File: rtl/cc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cc_seq_ctrl
//
// Purpose:
//    Sequencing controller for the 4-bit mod-11 state counter
//    (0 -> 1 -> ... -> 10 -> 0). It owns the state register ea and decides
//    when ea advances. The counter can be free-running, paused,
//    single-stepped, or stopped after a programmed number of laps.
//
// Parameters:
//    LAPS      full 0..10 laps before entering DONE; 0 means free-run
//    PRESCALE  clock cycles per advance while running, 1..256
//
// Ports:
//    clk      in   system clock, rising edge
//    rst_n    in   asynchronous active-low reset
//    bus      slave modport of cc_seq_ctrl_if:
//                start/stop/step in, ea/wrap/lap_cnt/busy/done out
//
// All outputs come straight from flops. No combinational path runs from
// the command inputs to any output.
// ---------------------------------------------------------------------------
module cc_seq_ctrl #(
   parameter int LAPS     = 2,
   parameter int PRESCALE = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   cc_seq_ctrl_if.slave  bus
);

   // The prescale counter only needs to reach PRESCALE-1. It keeps at
   // least one bit so that PRESCALE=1 still elaborates cleanly.
   localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_next;

   logic [3:0]     ea_q;
   logic [3:0]     ea_next;
   logic [7:0]     lap_q;
   logic [7:0]     lap_next;
   logic [PW-1:0]  pre_q;
   logic [PW-1:0]  pre_next;
   logic           wrap_q;
   logic           wrap_next;
   logic           busy_q;
   logic           done_q;

   logic [3:0]     adv_ea;
   logic           adv_wrap;
   logic [7:0]     lap_inc;
   logic           do_adv;

   // Advance function of the mod-11 counter.
   // Legal codes 0..9 count up. Code 10 wraps to 0 and flags a lap.
   // The unreachable codes 11..15 fall back to 0 quietly. They do not
   // count as a lap, so a corrupted register cannot fake a wrap pulse.
   always_comb begin
      adv_ea   = 4'd0;
      adv_wrap = 1'b0;
      if (ea_q < 4'd10) begin
         adv_ea = ea_q + 4'd1;
      end else if (ea_q == 4'd10) begin
         adv_wrap = 1'b1;
      end
   end

   // Lap count after one more completed lap. It sticks at 255 so a long
   // free-run never rolls the count back to a small number.
   always_comb begin
      lap_inc = (lap_q == 8'hFF) ? lap_q : lap_q + 8'd1;
   end

   // Next-state and datapath decisions.
   // First the command decode picks the next state and says whether an
   // advance happens on this edge. Then one shared block applies that
   // advance, so the RUN and PAUSE-step paths handle wrap, lap counting
   // and the DONE check the same way. Priority is stop > start > step in
   // every state. A stop in RUN wins even over a due prescale tick.
   always_comb begin
      state_next = state;
      ea_next    = ea_q;
      lap_next   = lap_q;
      pre_next   = pre_q;
      wrap_next  = 1'b0;
      do_adv     = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = RUN;
               ea_next    = 4'd0;
               lap_next   = 8'd0;
               pre_next   = '0;
            end
         end

         RUN: begin
            if (bus.stop) begin
               state_next = PAUSE;
               pre_next   = '0;
            end else if (pre_q == PRE_MAX) begin
               do_adv   = 1'b1;
               pre_next = '0;
            end else begin
               pre_next = pre_q + PW'(1);
            end
         end

         PAUSE: begin
            if (bus.stop) begin
               state_next = IDLE;
               ea_next    = 4'd0;
               lap_next   = 8'd0;
               pre_next   = '0;
            end else if (bus.start) begin
               state_next = RUN;
               pre_next   = '0;
            end else if (bus.step) begin
               do_adv = 1'b1;
            end
         end

         DONE: begin
            if (bus.stop) begin
               state_next = IDLE;
               ea_next    = 4'd0;
               lap_next   = 8'd0;
               pre_next   = '0;
            end else if (bus.start) begin
               state_next = RUN;
               ea_next    = 4'd0;
               lap_next   = 8'd0;
               pre_next   = '0;
            end
         end

         default: begin
            state_next = IDLE;
            ea_next    = 4'd0;
            lap_next   = 8'd0;
            pre_next   = '0;
         end
      endcase

      // A completed lap may finish the programmed run on the same edge.
      // Then ea lands on 0 and the wrap pulse coincides with done rising.
      if (do_adv) begin
         ea_next = adv_ea;
         if (adv_wrap) begin
            wrap_next = 1'b1;
            lap_next  = lap_inc;
            if ((LAPS != 0) && (int'({24'd0, lap_inc}) == LAPS)) begin
               state_next = DONE;
            end
         end
      end
   end

   // State and datapath registers.
   // busy and done are registered from the next state, not decoded from
   // the current state. They therefore change on the same edge as the
   // state they describe, and the outputs stay pure flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ea_q   <= 4'd0;
         lap_q  <= 8'd0;
         pre_q  <= '0;
         wrap_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         ea_q   <= ea_next;
         lap_q  <= lap_next;
         pre_q  <= pre_next;
         wrap_q <= wrap_next;
         busy_q <= (state_next == RUN);
         done_q <= (state_next == DONE);
      end
   end

   // Drive the status side of the interface from the registers above.
   assign bus.ea      = ea_q;
   assign bus.wrap    = wrap_q;
   assign bus.lap_cnt = lap_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule
